// File: rtl/i2c_bit_controller_if.sv
// I2C bit controller bundle: command/response handshake plus
// open-drain pad levels and enables.
interface i2c_bit_controller_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_code;
  logic       cmd_wdata;
  logic       rsp_valid;
  logic       rsp_rdata;
  logic       arb_lost;
  logic       bus_busy;
  logic       scl_in;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;

  modport master (
    output cmd_valid, cmd_code, cmd_wdata,
    output scl_in, sda_in,
    input  cmd_ready, rsp_valid, rsp_rdata,
    input  arb_lost, bus_busy,
    input  scl_oe, sda_oe
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_wdata,
    input  scl_in, sda_in,
    output cmd_ready, rsp_valid, rsp_rdata,
    output arb_lost, bus_busy,
    output scl_oe, sda_oe
  );
endinterface

// File: rtl/i2c_bit_controller.sv
// I2C bit sequencer: one START/STOP/WRITE/READ primitive per command,
// quarter-bit phases, clock stretching and arbitration-loss detection.
module i2c_bit_controller #(
  parameter int CLK_DIV_QUARTER = 250,
  parameter int SYNC_STAGES     = 2
) (
  input logic                 clock_in,
  input logic                 reset_n,
  i2c_bit_controller_if.slave bus
);

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [15:0] LAST =
    16'(CLK_DIV_QUARTER - 1);

  if (CLK_DIV_QUARTER < 4 ||
      CLK_DIV_QUARTER > 65535) begin : g_bad_div
    $error("CLK_DIV_QUARTER out of range");
  end
  if (SYNC_STAGES < 2 ||
      SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_phase, w_phase;
  logic [15:0] r_cnt, w_cnt;
  logic [1:0]  r_code, w_code;
  logic        r_wdata, w_wdata;
  logic        r_lost, w_lost;
  logic        r_scl_oe, w_scl_oe;
  logic        r_sda_oe, w_sda_oe;
  logic        r_rsp_valid, w_rsp_valid;
  logic        r_rdata, w_rdata;
  logic        r_arb, w_arb;
  logic        r_busy, w_busy;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic        w_scl, w_sda;
  logic        w_ready, w_accept, w_tick;

  // Returns {scl_oe, sda_oe}; a lost bit releases both lines in Q3.
  function automatic logic [1:0] f_drive(
    input logic [1:0] code,
    input logic [1:0] ph,
    input logic       wd,
    input logic       lost
  );
    logic scl;
    logic sda;
    scl = (ph == 2'd0) || (ph == 2'd3);
    sda = 1'b0;
    unique case (1'b1)
      code == C_START: sda = ph[1];
      code == C_STOP: begin
        scl = (ph == 2'd0);
        sda = (ph != 2'd3);
      end
      code == C_WRITE: sda = ~wd;
      default: sda = 1'b0;
    endcase
    if (lost && ph == 2'd3) begin
      scl = 1'b0;
      sda = 1'b0;
    end
    return {scl, sda};
  endfunction

  assign w_scl    = r_scl_sync[SYNC_STAGES-1];
  assign w_sda    = r_sda_sync[SYNC_STAGES-1];
  assign w_ready  = (r_state != S_RUN);
  assign w_accept = bus.cmd_valid & w_ready;
  assign w_tick   = (r_cnt == LAST);

  always_comb begin
    w_state     = r_state;
    w_phase     = r_phase;
    w_cnt       = r_cnt;
    w_code      = r_code;
    w_wdata     = r_wdata;
    w_lost      = r_lost;
    w_scl_oe    = r_scl_oe;
    w_sda_oe    = r_sda_oe;
    w_rsp_valid = 1'b0;
    w_rdata     = r_rdata;
    w_arb       = r_arb;
    w_busy      = r_busy;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_state = S_IDLE;
        if (w_accept) begin
          w_state = S_RUN;
          w_phase = 2'd0;
          w_cnt   = 16'd0;
          w_code  = bus.cmd_code;
          w_wdata = bus.cmd_wdata;
          w_lost  = 1'b0;
          {w_scl_oe, w_sda_oe} = f_drive(
            bus.cmd_code, 2'd0,
            bus.cmd_wdata, 1'b0);
          if (bus.cmd_code == C_START) begin
            w_busy = 1'b1;
            w_arb  = 1'b0;
          end
        end
      end
      S_RUN: begin
        // Q1 stays at count 0 until SCL is really high.
        if (r_phase == 2'd1 && !w_scl) begin
          w_cnt = 16'd0;
        end else if (!w_tick) begin
          w_cnt = r_cnt + 16'd1;
        end else begin
          w_cnt = 16'd0;
          if (r_phase == 2'd3) begin
            w_state     = S_DONE;
            w_rsp_valid = 1'b1;
            if (r_code == C_STOP) w_busy = 1'b0;
          end else begin
            w_phase = 2'(r_phase + 2'd1);
            if (r_phase == 2'd2) begin
              w_rdata = w_sda;
              if (r_code == C_WRITE &&
                  r_wdata && !w_sda) begin
                w_lost = 1'b1;
                w_arb  = 1'b1;
                w_busy = 1'b0;
              end
            end
            {w_scl_oe, w_sda_oe} = f_drive(
              r_code, w_phase, r_wdata, w_lost);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_phase     <= 2'd0;
      r_cnt       <= 16'd0;
      r_code      <= 2'd0;
      r_wdata     <= 1'b0;
      r_lost      <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 1'b0;
      r_arb       <= 1'b0;
      r_busy      <= 1'b0;
      r_scl_sync  <= '1;
      r_sda_sync  <= '1;
    end else begin
      r_state     <= w_state;
      r_phase     <= w_phase;
      r_cnt       <= w_cnt;
      r_code      <= w_code;
      r_wdata     <= w_wdata;
      r_lost      <= w_lost;
      r_scl_oe    <= w_scl_oe;
      r_sda_oe    <= w_sda_oe;
      r_rsp_valid <= w_rsp_valid;
      r_rdata     <= w_rdata;
      r_arb       <= w_arb;
      r_busy      <= w_busy;
      r_scl_sync  <= {r_scl_sync[SYNC_STAGES-2:0],
                      bus.scl_in};
      r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0],
                      bus.sda_in};
    end
  end

  assign bus.cmd_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.arb_lost  = r_arb;
  assign bus.bus_busy  = r_busy;
  assign bus.scl_oe    = r_scl_oe;
  assign bus.sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_bit_controller.sv
// Scoreboard bench for i2c_bit_controller: directed commands push
// expected responses, a negedge monitor pops and compares them.
module tb_i2c_bit_controller;

  localparam int N = 4;
  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  typedef struct packed {
    logic [31:0] cyc;
    logic        rd;
    logic        arb;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic scl_ext;
  logic sda_ext;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  i2c_bit_controller_if bus();

  i2c_bit_controller #(
    .CLK_DIV_QUARTER(N),
    .SYNC_STAGES(2)
  ) dut (
    .clock_in(clk),
    .reset_n(rst_n),
    .bus(bus)
  );

  assign bus.scl_in = scl_ext;
  assign bus.sda_in = ~bus.sda_oe & sda_ext;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at cycle %0d",
               name, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_cycle", cyc, mon_e.cyc);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_e.rd));
        chk("rsp_arb_lost", 32'(bus.arb_lost), 32'(mon_e.arb));
        chk("rsp_bus_busy", 32'(bus.bus_busy), 32'(mon_e.busy));
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input logic [1:0] code, input logic wd,
                       input bit push, input logic er,
                       input logic ea, input logic eb,
                       input int extra, output int a);
    int n;
    exp_t e;
    n = 0;
    bus.cmd_code  = code;
    bus.cmd_wdata = wd;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
    a = cyc;
    if (push) begin
      e.cyc  = 32'(a + 4 * N + 1 + extra);
      e.rd   = er;
      e.arb  = ea;
      e.busy = eb;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic at(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic lines(input string name,
                       input logic scl, input logic sda);
    chk({name, "_scl_oe"}, 32'(bus.scl_oe), 32'(scl));
    chk({name, "_sda_oe"}, 32'(bus.sda_oe), 32'(sda));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int a, a1, a2, a3;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_code  = 2'b00;
    bus.cmd_wdata = 1'b0;
    scl_ext = 1'b1;
    sda_ext = 1'b1;
    repeat (3) @(negedge clk);
    lines("reset", 1'b0, 1'b0);
    chk("reset_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_busy", 32'(bus.bus_busy), 32'd0);
    chk("reset_arb", 32'(bus.arb_lost), 32'd0);
    chk("reset_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rdata", 32'(bus.rsp_rdata), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    issue(C_START, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, a);
    at(a + 1);
    lines("start_q0", 1'b1, 1'b0);
    chk("start_busy", 32'(bus.bus_busy), 32'd1);
    at(a + 5);
    lines("start_q1", 1'b0, 1'b0);
    at(a + 9);
    lines("start_q2", 1'b0, 1'b1);
    at(a + 13);
    lines("start_q3", 1'b1, 1'b1);
    at(a + 16);
    chk("start_no_early_rsp", 32'(bus.rsp_valid), 32'd0);
    at(a + 18);
    chk("start_rsp_one_cycle", 32'(bus.rsp_valid), 32'd0);
    chk("start_idle_ready", 32'(bus.cmd_ready), 32'd1);
    drain();

    issue(C_WRITE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, a1);
    chk("wr1_sda_oe", 32'(bus.sda_oe), 32'd0);
    issue(C_WRITE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, a2);
    chk("wr0_sda_oe", 32'(bus.sda_oe), 32'd1);
    issue(C_WRITE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, a3);
    chk("wr1b_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("b2b_gap1", 32'(a2 - a1), 32'd17);
    chk("b2b_gap2", 32'(a3 - a2), 32'd17);
    drain();

    sda_ext = 1'b0;
    issue(C_READ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, a);
    chk("rd_sda_oe", 32'(bus.sda_oe), 32'd0);
    drain();
    sda_ext = 1'b1;
    issue(C_READ, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, a);
    drain();

    issue(C_WRITE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 22, a);
    repeat (4) @(posedge clk);
    #1;
    scl_ext = 1'b0;
    at(a + 20);
    lines("stretch_q1", 1'b0, 1'b1);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < a + 25);
    scl_ext = 1'b1;
    at(a + 34);
    lines("stretch_q2", 1'b0, 1'b1);
    at(a + 35);
    lines("stretch_q3", 1'b1, 1'b1);
    drain();

    sda_ext = 1'b0;
    issue(C_WRITE, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, a);
    at(a + 9);
    lines("arb_q2", 1'b0, 1'b0);
    chk("arb_q2_flag", 32'(bus.arb_lost), 32'd0);
    at(a + 13);
    lines("arb_q3", 1'b0, 1'b0);
    chk("arb_set", 32'(bus.arb_lost), 32'd1);
    chk("arb_busy", 32'(bus.bus_busy), 32'd0);
    drain();
    sda_ext = 1'b1;
    issue(C_START, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, a);
    chk("arb_clear", 32'(bus.arb_lost), 32'd0);
    chk("restart_busy", 32'(bus.bus_busy), 32'd1);
    lines("restart_q0", 1'b1, 1'b0);
    drain();

    issue(C_STOP, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, a);
    at(a + 5);
    lines("stop_q1", 1'b0, 1'b1);
    at(a + 18);
    lines("stop_end", 1'b0, 1'b0);
    chk("stop_busy", 32'(bus.bus_busy), 32'd0);
    drain();

    issue(C_WRITE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, a);
    at(a + 10);
    lines("abort_q2", 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    lines("abort_async", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_ready", 32'(bus.cmd_ready), 32'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
